mvm_seq: RTL and testbench
==========================

# mvm_seq

Parametrised sequential matrix-vector multiplier for the accelerator datapath: computes `result_vector = matrix × vector` over unsigned WIDTH-bit elements, using one multiply-accumulate lane per matrix row and one shared-dimension column per clock. It adds a start/busy/done handshake, a wide internal accumulator and optional output saturation. It sits between the layer-weight/activation staging registers and the activation stage.

## Interface
- `MATRIX_ROWS`, 3, number of matrix rows and output elements
- `SHARED_DIM`, 3, number of matrix columns and vector elements (≥1)
- `WIDTH`, 8, element width, unsigned
- `ACC_WIDTH`, 2*WIDTH+$clog2(SHARED_DIM)+1, accumulator width; must be ≥ 2*WIDTH+ceil(log2(SHARED_DIM))

- `clk` input 1 — sole clock, rising edge
- `reset` input 1 — synchronous, active-high
- `start` input 1 — request a new product; sampled only in IDLE
- `matrix` input MATRIX_ROWS*SHARED_DIM*WIDTH — element (r,c) at `[(MATRIX_ROWS*SHARED_DIM-1-(r*SHARED_DIM+c))*WIDTH +: WIDTH]` (row 0, col 0 in MSBs)
- `vector` input SHARED_DIM*WIDTH — element c at `[(SHARED_DIM-1-c)*WIDTH +: WIDTH]`
- `busy` output 1 — high while an operation is in flight (RUN or DONE)
- `done` output 1 — one-cycle pulse when `result_vector` updates
- `result_vector` output MATRIX_ROWS*WIDTH — row r at `[(MATRIX_ROWS-1-r)*WIDTH +: WIDTH]`, registered

## Operation
- States: IDLE, RUN, DONE.
- IDLE: if `start`, latch `matrix` and `vector` into internal registers, clear all accumulators, clear column counter, go to RUN. Otherwise stay.
- RUN: each cycle, for every row r: `acc[r] += M[r][col] * V[col]`. This is a full-precision product zero-extended to ACC_WIDTH. `col` increments; after `col == SHARED_DIM-1` go to DONE.
- DONE: write the reduced accumulators to `result_vector`, pulse `done`, return to IDLE.
- Reduction without saturation: `result[r] = acc[r][WIDTH-1:0]` (wrap modulo 2^WIDTH).
- Inputs changing after the start cycle have no effect on the operation in flight.
- `start` in RUN or DONE is ignored, not queued.
- `result_vector` holds its last value until the next DONE.
- Reset: state goes to IDLE, and `busy`, `done`, `result_vector`, accumulators and counter all go to 0. Reset mid-operation aborts with no `done` pulse. Reset wins over a simultaneous `start`.

## Timing
- `start` is sampled at edge k. `busy` is high after edge k.
- RUN spans edges k+1 … k+SHARED_DIM.
- `result_vector` is valid and `done` = 1 after edge k+SHARED_DIM+1, for that cycle only. `busy` falls at that edge too.
- Latency: SHARED_DIM+1 cycles from the start edge to result (4 for the defaults).
- Back-to-back: a `start` held high through the `done` cycle is accepted at the next edge. Throughput is one product per SHARED_DIM+2 cycles.
- Single-cycle MAC path; no internal pipelining.

## Configuration
- `MVM_SATURATE_EN` defined: if `acc[r] > 2^WIDTH-1`, then `result[r] = 2^WIDTH-1`; otherwise it is the low WIDTH bits.
- `MVM_SATURATE_EN` undefined: wrap (low WIDTH bits only). Timing is identical in both builds.

## Test plan
- Basic, default parameters: matrix 72'h010203040506070809, vector 24'h010203, pulse start. Expect `result_vector` = 24'h0E2032 with `done` exactly 4 cycles after the start edge, and `busy` high for 4 cycles.
- Near-full range: matrix 72'h0A0B0C0D0E0F101111, vector 24'h040506. Expect 24'hA7D4FB in both builds.
- Overflow: matrix 72'h131415161718191A1B, vector 24'h070809. Expect 24'hE22A72 without `MVM_SATURATE_EN` and 24'hFFFFFF with it.
- Input isolation / ignored start: after the basic start, change `matrix` and `vector` to all-FF and re-assert `start` during RUN. Expect 24'h0E2032 and a single `done` pulse.
- Reset mid-operation: assert `reset` 2 cycles after start. Expect `result_vector` = 0, `busy` = 0 and no `done`. A subsequent basic start completes normally.
- Parametrised build with MATRIX_ROWS=2, SHARED_DIM=4, WIDTH=16: matrix rows {1,2,3,4} and {FFFF,FFFF,FFFF,FFFF}, vector {1,1,1,1}. Expect row0 = 16'h000A and row1 = 16'hFFFC (wrap) or 16'hFFFF (saturate), with `done` 5 cycles after start.

Source files
------------

// File: rtl/mvm_seq.sv
// Sequential matrix-vector multiplier: one MAC lane per row, one shared-dim column per clock.
// Build option: define MVM_SATURATE_EN to clamp each result element instead of wrapping.
//
// state | meaning
// IDLE  | waiting for start; result_vector holds the last product
// RUN   | one column of MACs per cycle, SHARED_DIM cycles
// DONE  | reduce accumulators into result_vector, pulse done
module mvm_seq #(
  parameter int MATRIX_ROWS = 3,
  parameter int SHARED_DIM  = 3,
  parameter int WIDTH       = 8,
  parameter int ACC_WIDTH   = 2*WIDTH + $clog2(SHARED_DIM) + 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic [MATRIX_ROWS*SHARED_DIM*WIDTH-1:0] matrix,
  input  logic [SHARED_DIM*WIDTH-1:0]             vector,
  output logic                                    busy,
  output logic                                    done,
  output logic [MATRIX_ROWS*WIDTH-1:0]            result_vector
);

  localparam int CW = (SHARED_DIM > 1) ? $clog2(SHARED_DIM) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                                  state;
  logic [MATRIX_ROWS*SHARED_DIM*WIDTH-1:0] m_reg;
  logic [SHARED_DIM*WIDTH-1:0]             v_reg;
  logic [ACC_WIDTH-1:0]                    acc [MATRIX_ROWS];
  logic [CW-1:0]                           col;

  logic [WIDTH-1:0]   v_sel;
  logic [WIDTH-1:0]   m_sel [MATRIX_ROWS];
  logic [2*WIDTH-1:0] prod  [MATRIX_ROWS];

  // Column select is a compare-mux so non-power-of-two SHARED_DIM never indexes past the end.
  always_comb begin
    v_sel = '0;
    for (int c = 0; c < SHARED_DIM; c++) begin
      if (col == CW'(c)) v_sel = v_reg[(SHARED_DIM-1-c)*WIDTH +: WIDTH];
    end
    for (int r = 0; r < MATRIX_ROWS; r++) begin
      m_sel[r] = '0;
      for (int c = 0; c < SHARED_DIM; c++) begin
        if (col == CW'(c))
          m_sel[r] = m_reg[(MATRIX_ROWS*SHARED_DIM-1-(r*SHARED_DIM+c))*WIDTH +: WIDTH];
      end
      prod[r] = (2*WIDTH)'(m_sel[r]) * (2*WIDTH)'(v_sel);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      result_vector <= '0;
      col           <= '0;
      m_reg         <= '0;
      v_reg         <= '0;
      for (int r = 0; r < MATRIX_ROWS; r++) acc[r] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= matrix;
            v_reg <= vector;
            col   <= '0;
            busy  <= 1'b1;
            state <= RUN;
            for (int r = 0; r < MATRIX_ROWS; r++) acc[r] <= '0;
          end
        end
        RUN: begin
          for (int r = 0; r < MATRIX_ROWS; r++) acc[r] <= acc[r] + ACC_WIDTH'(prod[r]);
          if (col == CW'(SHARED_DIM-1)) begin
            col   <= '0;
            state <= DONE;
          end else begin
            col <= col + 1'b1;
          end
        end
        DONE: begin
          for (int r = 0; r < MATRIX_ROWS; r++) begin
`ifdef MVM_SATURATE_EN
            if (|acc[r][ACC_WIDTH-1:WIDTH])
              result_vector[(MATRIX_ROWS-1-r)*WIDTH +: WIDTH] <= '1;
            else
              result_vector[(MATRIX_ROWS-1-r)*WIDTH +: WIDTH] <= acc[r][WIDTH-1:0];
`else
            result_vector[(MATRIX_ROWS-1-r)*WIDTH +: WIDTH] <= acc[r][WIDTH-1:0];
`endif
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_seq.sv
// Self-checking bench for mvm_seq: directed vectors, randomized products against an
// arithmetic reference model, handshake timing, reset abort and a 2x4x16 instance.
module tb_mvm_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [71:0] matrix;
  logic [23:0] vector;
  logic        busy;
  logic        done;
  logic [23:0] result_vector;

  logic         p_start;
  logic [127:0] p_matrix;
  logic [63:0]  p_vector;
  logic         p_busy;
  logic         p_done;
  logic [31:0]  p_result;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mvm_seq u_dut (
    .clk(clk), .reset(reset), .start(start), .matrix(matrix), .vector(vector),
    .busy(busy), .done(done), .result_vector(result_vector)
  );

  mvm_seq #(.MATRIX_ROWS(2), .SHARED_DIM(4), .WIDTH(16)) u_dut_p (
    .clk(clk), .reset(reset), .start(p_start), .matrix(p_matrix), .vector(p_vector),
    .busy(p_busy), .done(p_done), .result_vector(p_result)
  );

  // Reference: sum of products per row in plain integers, then wrap or clamp.
  function automatic logic [255:0] mvm_model(input logic [255:0] m, input logic [255:0] v,
                                             input int rows, input int dim, input int w);
    logic [255:0]    res;
    longint unsigned mask, sum, a, b, red;
    res  = '0;
    mask = (64'd1 << w) - 64'd1;
    for (int r = 0; r < rows; r++) begin
      sum = 0;
      for (int c = 0; c < dim; c++) begin
        a = 64'(m >> ((rows*dim-1-(r*dim+c))*w)) & mask;
        b = 64'(v >> ((dim-1-c)*w)) & mask;
        sum += a * b;
      end
`ifdef MVM_SATURATE_EN
      red = (sum > mask) ? mask : sum;
`else
      red = sum & mask;
`endif
      res |= 256'(red) << ((rows-1-r)*w);
    end
    return res;
  endfunction

  // Drive one start pulse (caller is at a negedge) and observe until done or timeout.
  task automatic run_op(input logic [71:0] m, input logic [23:0] v,
                        output int lat, output int busy_cycles, output logic [23:0] res);
    matrix = m;
    vector = v;
    start  = 1'b1;
    lat = -1;
    busy_cycles = 0;
    res = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (busy) busy_cycles++;
      if (done) begin
        lat = i - 1;
        res = result_vector;
        return;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; matrix = '0; vector = '0;
    p_start = 1'b0; p_matrix = '0; p_vector = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result_vector !== 24'h0) begin
      failures++;
      $display("FAIL reset_state busy=%b done=%b result=%h required 0 0 000000", busy, done, result_vector);
    end
    // reset wins over a simultaneous start
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_vs_start busy=%b required 0", busy);
    end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [71:0] m [3];
    logic [23:0] v [3];
    logic [23:0] exp_r [3];
    int lat, bc;
    logic [23:0] res;
    m[0] = 72'h010203040506070809; v[0] = 24'h010203; exp_r[0] = 24'h0E2032;
    m[1] = 72'h0A0B0C0D0E0F101111; v[1] = 24'h040506; exp_r[1] = 24'hA7D4FB;
    m[2] = 72'h131415161718191A1B; v[2] = 24'h070809;
`ifdef MVM_SATURATE_EN
    exp_r[2] = 24'hFFFFFF;
`else
    exp_r[2] = 24'hE22A72;
`endif
    for (int t = 0; t < 3; t++) begin
      run_op(m[t], v[t], lat, bc, res);
      checks++;
      if (res !== exp_r[t]) begin
        failures++;
        $display("FAIL directed_%0d result=%h required %h", t, res, exp_r[t]);
      end
      checks++;
      if (lat != 4 || bc != 4) begin
        failures++;
        $display("FAIL directed_timing_%0d latency=%0d busy_cycles=%0d required 4 4", t, lat, bc);
      end
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL directed_busy_fall_%0d busy=%b required 0", t, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || result_vector !== exp_r[t]) begin
        failures++;
        $display("FAIL directed_hold_%0d done=%b result=%h required 0 %h", t, done, result_vector, exp_r[t]);
      end
    end
  endtask

  task automatic test_random;
    logic [95:0] rm;
    logic [23:0] rv, exp_v, res;
    int lat, bc, gap;
    for (int n = 0; n < 25; n++) begin
      rm = {$urandom, $urandom, $urandom};
      rv = 24'($urandom);
      exp_v = 24'(mvm_model(256'(rm[71:0]), 256'(rv), 3, 3, 8));
      run_op(rm[71:0], rv, lat, bc, res);
      checks++;
      if (res !== exp_v || lat != 4) begin
        failures++;
        $display("FAIL random_%0d result=%h latency=%0d required %h 4", n, res, lat, exp_v);
      end
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic test_isolation;
    int dones;
    matrix = 72'h010203040506070809;
    vector = 24'h010203;
    start  = 1'b1;
    dones  = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) begin
        matrix = '1;
        vector = '1;
      end
      if (i == 4) start = 1'b0;
      if (done) begin
        dones++;
        checks++;
        if (result_vector !== 24'h0E2032) begin
          failures++;
          $display("FAIL isolation_result result=%h required 0e2032", result_vector);
        end
      end
    end
    checks++;
    if (dones != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL isolation_done_count dones=%0d busy=%b required 1 0", dones, busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [95:0] r1, r2;
    logic [23:0] v1, v2, e1, e2;
    int t1, t2, dones;
    r1 = {$urandom, $urandom, $urandom}; v1 = 24'($urandom);
    r2 = {$urandom, $urandom, $urandom}; v2 = 24'($urandom);
    e1 = 24'(mvm_model(256'(r1[71:0]), 256'(v1), 3, 3, 8));
    e2 = 24'(mvm_model(256'(r2[71:0]), 256'(v2), 3, 3, 8));
    matrix = r1[71:0]; vector = v1; start = 1'b1;
    t1 = -1; t2 = -1; dones = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        matrix = r2[71:0];
        vector = v2;
      end
      if (done) begin
        dones++;
        if (t1 < 0) begin
          t1 = i - 1;
          checks++;
          if (result_vector !== e1) begin
            failures++;
            $display("FAIL b2b_first result=%h required %h", result_vector, e1);
          end
        end else begin
          t2 = i - 1;
          start = 1'b0;
          checks++;
          if (result_vector !== e2) begin
            failures++;
            $display("FAIL b2b_second result=%h required %h", result_vector, e2);
          end
        end
      end
      if (t1 >= 0 && i == t1 + 2) start = 1'b0;
    end
    checks++;
    if (t1 != 4 || t2 != 9 || dones != 2) begin
      failures++;
      $display("FAIL b2b_timing first=%0d second=%0d dones=%0d required 4 9 2", t1, t2, dones);
    end
  endtask

  task automatic test_reset_mid;
    int dones, lat, bc;
    logic [23:0] res;
    matrix = 72'h010203040506070809;
    vector = 24'h010203;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result_vector !== 24'h0) begin
      failures++;
      $display("FAIL reset_mid_state busy=%b done=%b result=%h required 0 0 000000", busy, done, result_vector);
    end
    reset = 1'b0;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_no_done dones=%0d busy=%b required 0 0", dones, busy);
    end
    run_op(72'h010203040506070809, 24'h010203, lat, bc, res);
    checks++;
    if (res !== 24'h0E2032 || lat != 4) begin
      failures++;
      $display("FAIL reset_mid_recover result=%h latency=%0d required 0e2032 4", res, lat);
    end
  endtask

  task automatic test_param;
    logic [31:0] exp_c, exp_m;
    logic [127:0] rm;
    int lat;
`ifdef MVM_SATURATE_EN
    exp_c = 32'h000AFFFF;
`else
    exp_c = 32'h000AFFFC;
`endif
    for (int t = 0; t < 4; t++) begin
      if (t == 0) begin
        p_matrix = {16'h0001, 16'h0002, 16'h0003, 16'h0004, {4{16'hFFFF}}};
        p_vector = {4{16'h0001}};
      end else begin
        rm = {$urandom, $urandom, $urandom, $urandom};
        p_matrix = rm;
        p_vector = {$urandom, $urandom};
      end
      exp_m = 32'(mvm_model(256'(p_matrix), 256'(p_vector), 2, 4, 16));
      p_start = 1'b1;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        if (i == 1) p_start = 1'b0;
        if (p_done) begin
          lat = i - 1;
          break;
        end
      end
      checks++;
      if (t == 0 && p_result !== exp_c) begin
        failures++;
        $display("FAIL param_directed result=%h required %h", p_result, exp_c);
      end else if (p_result !== exp_m || lat != 5) begin
        failures++;
        $display("FAIL param_%0d result=%h latency=%0d required %h 5", t, p_result, lat, exp_m);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_isolation;
    test_back_to_back;
    test_reset_mid;
    test_param;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
